plot_framebuffer_sink: RTL and testbench

- Receiving end of the game's pixel-plot interface (plot_en, x, y, colour).
- Buffers plot requests in a small FIFO and drains them into an internal 160x120x3 dual-port framebuffer.
- Continuously scans the framebuffer out in raster order for the display path.
- Provides a full-screen clear to a background colour so the controller can restart a round without erasing sprite by sprite.

---
 rtl/plot_framebuffer_sink.sv | 232 +++++++++++++++++++++++
 tb/tb_plot_framebuffer_sink.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/plot_framebuffer_sink.sv
// Pixel-plot sink: FIFO-buffered plot requests written into a 160x120x3 framebuffer, scanned out in raster order.
// Latency: a plot accepted on edge N (idle writer, empty FIFO) reaches RAM on edge N+1; scan outputs lag the counters by 1 cycle.
// Backpressure: none; requests that are out of range or arrive to a full FIFO are dropped and flagged (sticky oob/overflow).

// Small generic FIFO with combinational head; callers never push when full or pop when empty.
// Latency: pushed data is visible at the head the cycle after the push edge.
// Backpressure: exposes full/empty only; the owner decides what to do with a push into a full FIFO.
module plot_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  // Entry storage holds data only, so it carries no reset.
  always_ff @(posedge clock) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop_rdy)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_vld, pop_rdy})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_dat = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
endmodule

module plot_framebuffer_sink #(
  parameter int         H_RES      = 160,
  parameter int         V_RES      = 120,
  parameter int         H_TOTAL    = 200,
  parameter int         V_TOTAL    = 130,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [2:0] BG_COLOUR  = 3'b000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       plot_en,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       clear,
  output logic       clear_busy,
  output logic       overflow,
  output logic       oob,
  output logic [7:0] scan_x,
  output logic [6:0] scan_y,
  output logic [2:0] scan_colour,
  output logic       scan_valid,
  output logic       frame_start
);
  localparam int          FB_SIZE   = H_RES * V_RES;
  localparam logic [7:0]  H_LIM     = 8'(H_RES);
  localparam logic [6:0]  V_LIM     = 7'(V_RES);
  localparam logic [7:0]  V_ACT     = 8'(V_RES);
  localparam logic [7:0]  H_LAST    = 8'(H_TOTAL - 1);
  localparam logic [7:0]  V_LAST    = 8'(V_TOTAL - 1);
  localparam logic [14:0] ADDR_LAST = 15'(FB_SIZE - 1);
  localparam logic [14:0] H_MUL     = 15'(H_RES);

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } plot_req_t;

  typedef enum logic {IDLE, CLEAR} wr_state_t;

  // Row-major framebuffer address, kept to 15 bits throughout.
  function automatic logic [14:0] pix_addr(input logic [7:0] px, input logic [6:0] py);
    return 15'(py) * H_MUL + 15'(px);
  endfunction

  logic [2:0]  fb [FB_SIZE];
  plot_req_t   req_in;
  plot_req_t   req_head;
  logic        req_in_range;
  logic        req_push;
  logic        req_pop;
  logic        req_empty;
  logic        req_full;
  wr_state_t   state;
  wr_state_t   state_nxt;
  logic [14:0] clr_addr;
  logic        fb_we;
  logic [14:0] fb_waddr;
  logic [2:0]  fb_wdat;
  logic [7:0]  h_cnt;
  logic [7:0]  v_cnt;
  logic        scan_act;
  logic [14:0] fb_raddr;
  logic [2:0]  fb_rdat;

  assign req_in       = '{x: x, y: y, colour: colour};
  assign req_in_range = (x < H_LIM) && (y < V_LIM);
  // Full is the registered occupancy, so a same-cycle pop cannot make room.
  assign req_push     = plot_en && req_in_range && !req_full;

  plot_fifo #(.W($bits(plot_req_t)), .DEPTH(FIFO_DEPTH)) u_req_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_vld (req_push),
    .push_dat (req_in),
    .pop_rdy  (req_pop),
    .pop_dat  (req_head),
    .empty    (req_empty),
    .full     (req_full)
  );

  // Sticky drop flags; only reset clears them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      oob      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (plot_en && !req_in_range)            oob      <= 1'b1;
      if (plot_en && req_in_range && req_full) overflow <= 1'b1;
    end
  end

  // Writer state and the clear sweep address (held at 0 outside a clear).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= (state == CLEAR) ? clr_addr + 1'b1 : '0;
    end
  end

  // Writer: a clear request beats draining; the sweep ignores further clear pulses.
  always_comb begin
    state_nxt = state;
    req_pop   = 1'b0;
    fb_we     = 1'b0;
    fb_waddr  = '0;
    fb_wdat   = '0;
    case (state)
      IDLE: begin
        if (clear) begin
          state_nxt = CLEAR;
        end else if (!req_empty) begin
          req_pop  = 1'b1;
          fb_we    = 1'b1;
          fb_waddr = pix_addr(req_head.x, req_head.y);
          fb_wdat  = req_head.colour;
        end
      end
      CLEAR: begin
        fb_we    = 1'b1;
        fb_waddr = clr_addr;
        fb_wdat  = BG_COLOUR;
        if (clr_addr == ADDR_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clear_busy = (state == CLEAR);

  // Framebuffer write port.
  always_ff @(posedge clock) begin
    if (fb_we) fb[fb_waddr] <= fb_wdat;
  end

  // Free-running raster counters; never stalled by the writer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 8'd0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign scan_act = (h_cnt < H_LIM) && (v_cnt < V_ACT);
  assign fb_raddr = scan_act ? pix_addr(h_cnt, v_cnt[6:0]) : '0;

  // Read port; a same-address write this cycle is seen on the next frame.
  always_ff @(posedge clock) begin
    fb_rdat <= fb[fb_raddr];
  end

  // Scan position/timing outputs, aligned with the registered read data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_x      <= '0;
      scan_y      <= '0;
      scan_valid  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      scan_x      <= h_cnt;
      scan_y      <= v_cnt[6:0];
      scan_valid  <= scan_act;
      frame_start <= (h_cnt == 8'd0) && (v_cnt == 8'd0);
    end
  end

  assign scan_colour = scan_valid ? fb_rdat : 3'b000;
endmodule

// File: tb/tb_plot_framebuffer_sink.sv
// Directed bench for plot_framebuffer_sink: plots, drops, clear, scan timing and reset during a clear.
module tb_plot_framebuffer_sink;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       plot_en = 1'b0;
  logic [7:0] x = '0;
  logic [6:0] y = '0;
  logic [2:0] colour = '0;
  logic       clear = 1'b0;
  logic       clear_busy;
  logic       overflow;
  logic       oob;
  logic [7:0] scan_x;
  logic [6:0] scan_y;
  logic [2:0] scan_colour;
  logic       scan_valid;
  logic       frame_start;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] exp_fb [19200];

  int cyc = 0;
  int fs_count = 0, fs_first = -1, fs_second = -1;
  int valid_acc = 0, frame0_valid = 0;
  int run_len = 0, runs = 0, bad_runs = 0, bad_blank = 0;
  int busy_cnt = 0;
  bit cmp_en = 1'b0;
  bit seen53 = 1'b0;
  int cmp_pixels = 0, pix_err = 0, cnt6 = 0;

  plot_framebuffer_sink dut (
    .clock       (clock),
    .reset       (reset),
    .plot_en     (plot_en),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .clear       (clear),
    .clear_busy  (clear_busy),
    .overflow    (overflow),
    .oob         (oob),
    .scan_x      (scan_x),
    .scan_y      (scan_y),
    .scan_colour (scan_colour),
    .scan_valid  (scan_valid),
    .frame_start (frame_start)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int px, input int py, input int pc);
    @(negedge clock);
    plot_en = 1'b1;
    x = 8'(px);
    y = 7'(py);
    colour = 3'(pc);
  endtask

  task automatic idle();
    @(negedge clock);
    plot_en = 1'b0;
  endtask

  // Edge counter since reset release.
  always @(posedge clock) if (!reset) cyc++;

  // Scan monitor: frame timing, line runs, blanking, clear duration and frame 2 content.
  always @(negedge clock) begin
    if (!reset) begin
      if (frame_start) begin
        fs_count++;
        if (fs_count == 1) fs_first = cyc;
        if (fs_count == 2) begin
          fs_second = cyc;
          frame0_valid = valid_acc;
        end
        valid_acc = 0;
        cmp_en = (fs_count == 3);
      end
      if (scan_valid) begin
        valid_acc++;
        run_len++;
      end else if (run_len != 0) begin
        if (fs_count == 1) begin
          runs++;
          if (run_len != 160) bad_runs++;
        end
        run_len = 0;
      end
      if (!scan_valid && scan_colour != 3'b000) bad_blank++;
      if (clear_busy) busy_cnt++;
      if (cmp_en && scan_valid) begin
        cmp_pixels++;
        if (scan_colour !== exp_fb[int'(scan_y) * 160 + int'(scan_x)]) pix_err++;
        if (scan_colour == 3'b110) cnt6++;
        if (scan_x == 8'd5 && scan_y == 7'd3 && scan_colour == 3'b110) seen53 = 1'b1;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ov_x [17];
    int ov_y [17];
    int ov_c [17];
    int busy_base;

    for (int i = 0; i < 17; i++) begin
      ov_x[i] = 20 + i;
      ov_y[i] = 40;
      ov_c[i] = (i % 5) + 1;
    end
    ov_x[0]  = 10; ov_y[0]  = 10; ov_c[0]  = 2;
    ov_x[14] = 50; ov_y[14] = 50; ov_c[14] = 1;
    ov_x[15] = 50; ov_y[15] = 50; ov_c[15] = 4;
    ov_x[16] = 60; ov_y[16] = 60; ov_c[16] = 7;

    // Reset state.
    repeat (3) @(negedge clock);
    chk("rst_clear_busy", clear_busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_oob", oob, 0);
    chk("rst_scan_valid", scan_valid, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_scan_colour", scan_colour, 0);
    chk("rst_fifo_empty", dut.req_empty, 1);
    reset = 1'b0;

    // Single plot: written two edges after it is driven.
    drive(5, 3, 6);
    idle();
    @(negedge clock);
    chk("single_ram485", dut.fb[485], 6);
    chk("single_oob", oob, 0);
    chk("single_overflow", overflow, 0);

    // Out-of-range requests are dropped.
    drive(160, 0, 1);
    idle();
    chk("oob_x_flag", oob, 1);
    chk("oob_x_fifo_empty", dut.req_empty, 1);
    drive(0, 120, 1);
    idle();
    chk("oob_y_fifo_empty", dut.req_empty, 1);
    chk("oob_no_overflow", overflow, 0);

    // Fill the whole screen with 3'b111.
    for (int yy = 0; yy < 120; yy++) begin
      for (int xx = 0; xx < 160; xx++) begin
        drive(xx, yy, 7);
        exp_fb[yy * 160 + xx] = 3'b111;
      end
    end
    idle();
    repeat (3) @(negedge clock);
    chk("fill_first", dut.fb[0], 7);
    chk("fill_last_addr", dut.fb[19199], 7);
    chk("fill_fifo_empty", dut.req_empty, 1);

    // Clear, with 17 plots pushed while it runs.
    @(negedge clock);
    #1 busy_base = busy_cnt;
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("clear_busy_on", clear_busy, 1);
    for (int i = 0; i < 17; i++) begin
      drive(ov_x[i], ov_y[i], ov_c[i]);
      if (i == 16) begin
        chk("ovf_before_17th", overflow, 0);
        chk("ovf_fifo_full", dut.req_full, 1);
      end
    end
    idle();
    chk("ovf_flag", overflow, 1);
    for (int i = 0; i < 19200; i++) exp_fb[i] = 3'b000;
    for (int i = 0; i < 16; i++) exp_fb[ov_y[i] * 160 + ov_x[i]] = 3'(ov_c[i]);

    // A second clear pulse mid-sweep must not restart it.
    repeat (50) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;

    for (int k = 0; k < 20000 && clear_busy; k++) @(negedge clock);
    #1;
    chk("clear_done", clear_busy, 0);
    chk("clear_busy_len", busy_cnt - busy_base, 19200);
    @(negedge clock);
    repeat (14) @(negedge clock);
    chk("drain_15_not_empty", dut.req_empty, 0);
    @(negedge clock);
    chk("drain_16_empty", dut.req_empty, 1);
    chk("drain_10_10", dut.fb[1610], 2);
    chk("drain_order_50_50", dut.fb[8050], 4);
    chk("drain_dropped_60_60", dut.fb[9660], 0);

    // Re-plot (5,3) on the cleared screen and check write latency.
    drive(5, 3, 6);
    exp_fb[485] = 3'b110;
    idle();
    chk("lat_edge_n", dut.fb[485], 0);
    @(negedge clock);
    chk("lat_edge_n1", dut.fb[485], 6);

    // Let frame 2 scan out completely.
    for (int k = 0; k < 60000 && fs_count < 4; k++) @(negedge clock);
    #1;
    chk("frame2_done", fs_count >= 4, 1);
    chk("fs_first_cycle", fs_first, 1);
    chk("fs_period", fs_second - fs_first, 26000);
    chk("frame0_valid", frame0_valid, 19200);
    chk("frame0_lines", runs, 120);
    chk("frame0_bad_runs", bad_runs, 0);
    chk("blank_colour", bad_blank, 0);
    chk("frame2_pixels", cmp_pixels, 19200);
    chk("frame2_pix_err", pix_err, 0);
    chk("frame2_cnt6", cnt6, 1);
    chk("frame2_seen_5_3", seen53, 1);

    // Asynchronous reset part-way through a clear.
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    repeat (4999) @(posedge clock);
    #2;
    chk("pre_rst_busy", clear_busy, 1);
    reset = 1'b1;
    #1;
    chk("arst_clear_busy", clear_busy, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_oob", oob, 0);
    chk("arst_scan_valid", scan_valid, 0);
    chk("arst_scan_x", scan_x, 0);
    chk("arst_scan_y", scan_y, 0);
    chk("arst_scan_colour", scan_colour, 0);
    chk("arst_frame_start", frame_start, 0);
    @(negedge clock);
    reset = 1'b0;
    drive(7, 7, 5);
    idle();
    @(negedge clock);
    chk("post_rst_plot", dut.fb[1127], 5);
    chk("post_rst_idle", clear_busy, 0);
    chk("post_rst_oob", oob, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
